fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: the PC the unit fetches from after reset.
REQ-002 Parameter FIFO_DEPTH, default 2: the number of entries in the fetch buffer, which shall be a power of two and at least 2.
REQ-003 clk  in  1  the single clock; every state element updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 imem_req  out  1  the unit is requesting an instruction fetch.
REQ-006 imem_addr  out  16  the fetch address; it shall be word-aligned (bits [1:0]=0).
REQ-007 imem_ready  in  1  memory accepts the request in the current cycle.
REQ-008 imem_rvalid  in  1  read data is valid this cycle.
REQ-009 imem_rdata  in  32  instruction word.
REQ-010 redirect  in  1  redirect request from decode/execute (next_PC_select taken).
REQ-011 redirect_pc  in  16  target PC for a redirect.
REQ-012 if_valid  out  1  if_instruction/if_pc hold a valid entry.
REQ-013 if_ready  in  1  decode consumes the entry this cycle.
REQ-014 if_instruction  out  32  instruction at the FIFO head.
REQ-015 if_pc  out  16  PC of if_instruction.

Function
REQ-016 A request is "accepted" in a cycle where imem_req && imem_ready; an entry is "popped" in a cycle where if_valid && if_ready.
REQ-017 At most one request shall be outstanding; imem_req shall be high only in state RUN and only when FIFO free slots exceed the number of outstanding requests.
REQ-018 States: RUN (no outstanding request), WAIT (one outstanding request), DISCARD (one outstanding request whose response is stale).
REQ-019 RUN->WAIT on accept; WAIT->RUN on imem_rvalid; WAIT->DISCARD on redirect without imem_rvalid; DISCARD->RUN on imem_rvalid.
REQ-020 On accept, fetch_pc shall advance by 4 in the next cycle, wrapping modulo 2^16 (16'hFFFC -> 16'h0000).
REQ-021 In WAIT, imem_rvalid shall push {imem_rdata, pc of the request} into the FIFO in the same edge.
REQ-022 In DISCARD, the returning response shall be dropped and never pushed.
REQ-023 imem_rvalid in RUN shall be ignored.
REQ-024 On redirect: flush the FIFO (if_valid=0 next cycle), set fetch_pc=redirect_pc with bits [1:0] forced to 0, and take no accept that cycle (imem_req masked low); redirect takes priority over push and pop in the same cycle.
REQ-025 Push and pop in the same cycle on a full FIFO shall succeed, with no loss and no change in occupancy.
REQ-026 if_instruction/if_pc shall be driven from the FIFO head (registered storage) with no combinational path from imem_rdata.
REQ-027 Minimum latency: accept at cycle N with rvalid at N+1 gives if_valid at N+2.
REQ-028 Sustained throughput: one instruction per cycle is not required; one per two cycles is the minimum when memory answers in 1 cycle and if_ready=1.

Reset
REQ-029 While reset is high: state=RUN, fetch_pc=RESET_PC, FIFO empty, imem_req=0, if_valid=0, if_instruction=0, if_pc=0, and counters=0.
REQ-030 Reset asserted mid-request shall abandon the outstanding request, and a late imem_rvalid in the first cycle after reset shall be ignored (the unit is in RUN).

Configuration
REQ-031 Macro FETCH_PERF_CNT_EN: when defined, add outputs perf_fetched[31:0] (increments per push) and perf_flushed[31:0] (increments per redirect cycle), both wrapping; when undefined, these ports and their logic are absent and behaviour is otherwise identical.

Structure
REQ-032 A shared package riscv_pkg shall hold the PC width (16), instruction width (32), the fetch state enum {RUN, WAIT, DISCARD}, and the NOP constant 32'h00000013.
REQ-033 The FIFO shall be a sub-module fetch_fifo (parameterised depth, synchronous flush); the state machine and PC logic shall live in fetch_unit.

Verification
REQ-034 Reset with RESET_PC=16'h0100, memory latency 1, and if_ready=1 -> imem_addr sequence 0x0100, 0x0104, 0x0108, and if_pc follows in order.
REQ-035 if_ready=0 for 10 cycles -> the FIFO fills to FIFO_DEPTH, imem_req stays low, and no instruction is lost or duplicated when if_ready returns to 1.
REQ-036 redirect to 16'h0203 while in WAIT -> the stale response is dropped, the next imem_addr is 0x0200, and the first if_pc after the redirect is 0x0200.
REQ-037 Start at fetch_pc=16'hFFFC -> the next fetch address is 0x0000.
REQ-038 Full FIFO with simultaneous push and pop -> occupancy unchanged and ordering preserved.
REQ-039 With FETCH_PERF_CNT_EN defined, 5 pushes and 2 redirects -> perf_fetched=5 and perf_flushed=2.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-path definitions: datapath widths, fetch FSM states and the FIFO entry layout.
package riscv_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN,
    WAIT,
    DISCARD
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fetch_entry_t;

  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return {pc[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: power-of-two deep FIFO of {instruction, pc} with synchronous flush.
// The head is read straight from registered storage.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CNT_W'(DEPTH));
  assign valid = (count != '0);

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the storage is reset (cheap at this depth) so the head reads
      // zero while reset is held; larger memories would normally not be.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding request FSM, PC sequencing, redirect flush.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_flushed event counters.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC   = 16'h0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instruction,
  output logic [PC_W-1:0]    if_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_flushed
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e     state;
  fetch_state_e     state_next;
  logic [PC_W-1:0]  fetch_pc;
  logic [PC_W-1:0]  req_pc;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] free_slots;
  logic             outstanding;
  logic             accept;
  logic             push;
  fetch_entry_t     push_entry;
  fetch_entry_t     head_entry;

  assign free_slots = CNT_W'(FIFO_DEPTH) - fifo_count;
  assign accept     = imem_req && imem_ready;
  assign imem_addr  = fetch_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (accept) state_next = WAIT;
      end
      WAIT: begin
        if (imem_rvalid)   state_next = RUN;
        else if (redirect) state_next = DISCARD;
      end
      DISCARD: begin
        if (imem_rvalid) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  // NOTE: every output gets a default before any condition, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    outstanding = (state != RUN);
    imem_req    = 1'b0;
    push        = 1'b0;
    if (!reset && !redirect && state == RUN) begin
      imem_req = (free_slots > CNT_W'(outstanding));
    end
    // A response arriving with a redirect is dropped along with the flush.
    if (!reset && !redirect && state == WAIT) begin
      push = imem_rvalid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= align_pc(RESET_PC);
      req_pc   <= '0;
    end else if (redirect) begin
      fetch_pc <= align_pc(redirect_pc);
    end else if (accept) begin
      fetch_pc <= fetch_pc + PC_W'(4);
      req_pc   <= fetch_pc;
    end
  end

  assign push_entry = '{instr: imem_rdata, pc: req_pc};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (push),
    .push_data (push_entry),
    .pop       (if_ready),
    .head      (head_entry),
    .valid     (if_valid),
    .count     (fifo_count)
  );

  assign if_instruction = head_entry.instr;
  assign if_pc          = head_entry.pc;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (push)     perf_fetched <= perf_fetched + 32'd1;
      if (redirect) perf_flushed <= perf_flushed + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: a memory model answers requests, and the
// expected program-order PC stream (restarted on reset/redirect) is checked at every pop.
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam logic [PC_W-1:0] RST_PC = 16'h0100;
  localparam int              DEPTH  = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ready;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic               if_valid;
  logic               if_ready;
  logic [INSTR_W-1:0] if_instruction;
  logic [PC_W-1:0]    if_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]        perf_fetched;
  logic [31:0]        perf_flushed;
`endif

  fetch_unit #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instruction (if_instruction),
    .if_pc          (if_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_flushed   (perf_flushed)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory contents: a fixed function of the word address.
  function automatic logic [INSTR_W-1:0] mem_word(input logic [PC_W-1:0] a);
    return {a ^ 16'hA5C3, ~a};
  endfunction

  // Reference model: program-order PC stream from the last reset/redirect target.
  logic [PC_W-1:0] exp_q[$];
  logic [PC_W-1:0] q_next;
  logic [PC_W-1:0] exp_addr;

  function void extend();
    while (exp_q.size() < 8) begin
      exp_q.push_back(q_next);
      q_next = q_next + 16'd4;
    end
  endfunction

  function void restart(input logic [PC_W-1:0] pc);
    exp_q.delete();
    q_next   = {pc[PC_W-1:2], 2'b00};
    exp_addr = q_next;
    extend();
  endfunction

  // Knobs shared by stimulus and memory model.
  int   min_lat   = 0;
  int   max_lat   = 0;
  int   ready_pct = 100;
  int   ifr_pct   = 100;
  logic junk_en   = 1'b0;

  // Memory model state.
  logic pending = 1'b0;
  logic stale   = 1'b0;
  logic late    = 1'b0;
  logic rv_real = 1'b0;
  int   wait_cnt = 0;
  int   pushes   = 0;
  logic [INSTR_W-1:0] hold = '0;

  initial begin : mem_model
    logic            acc;
    logic [PC_W-1:0] acc_addr;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      acc      = imem_req && imem_ready;
      acc_addr = imem_addr;
      @(posedge clk);
      #2;
      if (acc) check("one_outstanding", 32'(pending), 32'd0);
      if (rv_real) pending = 1'b0;
      rv_real     = 1'b0;
      imem_rvalid = 1'b0;
      if (reset) begin
        pending     = 1'b0;
        stale       = 1'b0;
        late        = 1'b1;
        pushes      = 0;
        imem_rvalid = 1'b1;
        imem_rdata  = $urandom;
      end else if (late) begin
        // Late response from an abandoned request, first cycle out of reset.
        late        = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = $urandom;
      end else begin
        if (acc) begin
          pending  = 1'b1;
          stale    = 1'b0;
          wait_cnt = int'($urandom_range(max_lat, min_lat));
          hold     = mem_word(acc_addr);
        end
        if (pending) begin
          if (wait_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = hold;
            rv_real     = 1'b1;
            if (!stale && !redirect) pushes++;
          end else begin
            wait_cnt--;
          end
          if (redirect) stale = 1'b1;
        end else if (junk_en && $urandom_range(7) == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = $urandom;
        end
      end
      imem_ready = (int'($urandom_range(99)) < ready_pct);
    end
  end

  // Monitor / scoreboard.
  int   cyc = 0;
  int   pop_count = 0;
  int   flushes = 0;
  int   first_acc = -1;
  int   first_val = -1;
  logic prev_reset = 1'b0;
  logic prev_redirect = 1'b0;

  initial begin : monitor
    logic [PC_W-1:0] lpc;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        check("req_in_reset", 32'(imem_req), 32'd0);
        if (prev_reset) begin
          check("valid_in_reset", 32'(if_valid), 32'd0);
          check("instr_in_reset", if_instruction, 32'd0);
          check("pc_in_reset", 32'(if_pc), 32'd0);
        end
        flushes       = 0;
        first_acc     = -1;
        first_val     = -1;
        prev_redirect = 1'b0;
      end else begin
        if (prev_redirect) check("flush_valid", 32'(if_valid), 32'd0);
        if (redirect) begin
          check("req_masked", 32'(imem_req), 32'd0);
          flushes++;
        end else begin
          if (imem_req && imem_ready) begin
            check("imem_addr", 32'(imem_addr), 32'(exp_addr));
            exp_addr = exp_addr + 16'd4;
            if (first_acc < 0) first_acc = cyc;
          end
          if (if_valid && first_val < 0) first_val = cyc;
          if (if_valid && if_ready) begin
            lpc = exp_q.pop_front();
            extend();
            check("if_pc", 32'(if_pc), 32'(lpc));
            check("if_instruction", if_instruction, mem_word(lpc));
            pop_count++;
          end
        end
        prev_redirect = redirect;
      end
      prev_reset = reset;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input int redir_pct);
    for (int i = 0; i < n; i++) begin
      tick();
      if_ready = (int'($urandom_range(99)) < ifr_pct);
      redirect = 1'b0;
      if (redir_pct > 0 && int'($urandom_range(99)) < redir_pct) begin
        redirect    = 1'b1;
        redirect_pc = 16'($urandom);
        restart(redirect_pc);
      end
    end
  endtask

  // Waits (bounded) until a real request is outstanding and will not answer this cycle.
  task automatic wait_for_wait_state(output logic found);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if_ready = 1'b1;
      redirect = 1'b0;
      if (pending && !rv_real && wait_cnt != 0) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int   p0;
    logic found;
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    if_ready    = 1'b0;
    repeat (3) tick();

    // Sequential fetch from RESET_PC, 1-cycle memory, decode always ready.
    reset    = 1'b0;
    if_ready = 1'b1;
    restart(RST_PC);
    p0 = pop_count;
    run(40, 0);
    check("min_latency", 32'(first_val - first_acc), 32'd2);
    check("throughput", 32'((pop_count - p0) >= 19), 32'd1);

    // Decode stalls: buffer fills, requests stop, nothing lost on release.
    ifr_pct = 0;
    run(10, 0);
    @(negedge clk);
    check("stall_req_low", 32'(imem_req), 32'd0);
    check("stall_valid", 32'(if_valid), 32'd1);
    ready_pct = 0;
    ifr_pct   = 100;
    p0 = pop_count;
    run(6, 0);
    check("stall_occupancy", 32'(pop_count - p0), 32'(DEPTH));
    ready_pct = 100;

    // Redirect to an unaligned target while a request is outstanding.
    min_lat = 3;
    max_lat = 3;
    wait_for_wait_state(found);
    check("wait_reached", 32'(found), 32'd1);
    redirect    = 1'b1;
    redirect_pc = 16'h0203;
    restart(16'h0203);
    p0 = pop_count;
    run(30, 0);
    check("redirect_pops", 32'(pop_count > p0), 32'd1);

    // PC wrap at the top of the address space.
    min_lat = 0;
    max_lat = 1;
    tick();
    if_ready    = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 16'hFFFC;
    restart(16'hFFFC);
    p0 = pop_count;
    run(20, 0);
    check("wrap_pops", 32'((pop_count - p0) >= 3), 32'd1);

    // Reset in the middle of an outstanding request.
    min_lat = 2;
    max_lat = 3;
    wait_for_wait_state(found);
    check("wait_before_reset", 32'(found), 32'd1);
    reset    = 1'b1;
    redirect = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    restart(RST_PC);
    p0 = pop_count;
    run(40, 0);
    check("post_reset_pops", 32'(pop_count > p0), 32'd1);

    // Randomized traffic with redirects and spurious responses.
    min_lat   = 0;
    max_lat   = 2;
    ready_pct = 70;
    ifr_pct   = 60;
    junk_en   = 1'b1;
    run(3000, 3);

    // Quiesce before comparing event counts.
    junk_en   = 1'b0;
    ready_pct = 0;
    run(8, 0);
`ifdef FETCH_PERF_CNT_EN
    @(negedge clk);
    check("perf_fetched", perf_fetched, 32'(pushes));
    check("perf_flushed", perf_flushed, 32'(flushes));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
